md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low; 0 forces reset state immediately.
REQ-003 SHALL have port id_md_op, input, 1: ID-stage instruction is mult/multu/div/divu/mthi/mtlo.
REQ-004 SHALL have port id_mf_op, input, 1: ID-stage instruction is mfhi/mflo.
REQ-005 SHALL have port ex_md_valid, input, 1: EX-stage instruction is a mult/div-unit op.
REQ-006 SHALL have port ex_md_ctr, input, 3: EX op code; 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo.
REQ-007 SHALL have port flush, input, 1: interrupt/exception flush of EX and younger stages this cycle.
REQ-008 SHALL have port md_busy, input, 1: busy flag returned by the mult/div unit.
REQ-009 SHALL have port md_start, output, 1: launch pulse to the unit.
REQ-010 SHALL have port md_ctr, output, 3: op code to the unit; equals ex_md_ctr.
REQ-011 SHALL have port md_lock, output, 1: blocks unit start and mthi/mtlo writes.
REQ-012 SHALL have port md_restore, output, 1: commands the unit to roll HI/LO back and abort.
REQ-013 SHALL have port stall_id, output, 1: freezes IF/ID and bubbles EX.
REQ-014 SHALL have port md_done, output, 1: one-cycle pulse; HI/LO valid this cycle.
REQ-015 SHALL have port md_err, output, 1: sticky protocol/consistency error.
REQ-016 SHALL have port op_count, output, 16: count of launched, non-cancelled mult/div ops.

Function
REQ-017 SHALL implement FSM states IDLE, PEND, RUN; 2-bit encoding, no other reachable state.
REQ-018 SHALL assert md_start combinationally in IDLE when ex_md_valid, ex_md_ctr in 000..011, and flush=0.
REQ-019 SHALL, on a start edge, go to PEND and load rem with 4 (000/001) or 9 (010/011).
REQ-020 SHALL decrement rem once per cycle in PEND and RUN.
REQ-021 SHALL in PEND: flush=1 -> md_restore=1 this cycle, next state IDLE, rem cleared, op_count unchanged; flush=0 -> RUN.
REQ-022 SHALL treat flush in RUN as no-op; the op is committed and continues.
REQ-023 SHALL in RUN with rem==1 go to IDLE next edge and register md_done=1 for exactly that next cycle.
REQ-024 SHALL thus give HI/LO valid latency of T+5 (mult/multu) and T+10 (div/divu), T = md_start cycle.
REQ-025 SHALL increment op_count (mod 2^16, wrap 0xFFFF->0) on the PEND->RUN edge only.
REQ-026 SHALL assert md_lock = flush in every state.
REQ-027 SHALL pass mthi/mtlo (100/101) in IDLE with flush=0 straight through: no md_start, no state change.
REQ-028 SHALL assert stall_id = (id_md_op | id_mf_op) & (state != IDLE | md_start).
REQ-029 SHALL hold stall_id=0 for all other instructions, regardless of state.
REQ-030 SHALL set md_err if ex_md_valid=1 in PEND or RUN.
REQ-031 SHALL set md_err if ex_md_ctr is 110/111 with ex_md_valid=1.
REQ-032 SHALL set md_err if md_busy=0 in RUN with rem>1.
REQ-033 SHALL set md_err if md_busy=1 in the md_done cycle.
REQ-034 SHALL clear md_err only by reset.

Reset
REQ-035 SHALL on reset=0 force: state IDLE, rem 0, md_done 0, md_err 0, op_count 0.
REQ-036 SHALL drive md_start, md_restore, stall_id 0 during reset; md_lock follows flush.
REQ-037 SHALL abandon any in-flight op on reset mid-operation with no md_done pulse; normal operation resumes on the first edge after reset returns to 1.

Verification
REQ-038 SHALL cover: mult issued at T, mfhi in ID at T..T+5 -> stall_id=1 T..T+4, md_done=1 at T+5, stall_id=0 at T+5, op_count=1.
REQ-039 SHALL cover: divu issued at T -> md_done only at T+10; md_busy high T+1..T+9; md_err stays 0.
REQ-040 SHALL cover: mult at T, flush at T+1 -> md_restore=1 at T+1, IDLE at T+2, no md_done, op_count=0.
REQ-041 SHALL cover: div at T, flush at T+3 -> no restore, md_done at T+10, op_count=1.
REQ-042 SHALL cover: flush with ex_md_valid and ctr=000 in IDLE -> md_lock=1, md_start=0, state stays IDLE.
REQ-043 SHALL cover: 65536 committed mults -> op_count wraps to 0x0000; reset low at T+2 of a div -> IDLE immediately, no md_done.

Source files
------------

// File: rtl/md_issue_if.sv
// Signal bundle between the ID/EX pipeline, the mult/div unit and the issue controller.
// The pipeline and unit side uses master; the controller uses slave.
interface md_issue_if;
  logic        id_md_op;
  logic        id_mf_op;
  logic        ex_md_valid;
  logic [2:0]  ex_md_ctr;
  logic        flush;
  logic        md_busy;
  logic        md_start;
  logic [2:0]  md_ctr;
  logic        md_lock;
  logic        md_restore;
  logic        stall_id;
  logic        md_done;
  logic        md_err;
  logic [15:0] op_count;

  modport master (
    output id_md_op, id_mf_op, ex_md_valid, ex_md_ctr, flush, md_busy,
    input  md_start, md_ctr, md_lock, md_restore, stall_id, md_done, md_err, op_count
  );

  modport slave (
    input  id_md_op, id_mf_op, ex_md_valid, ex_md_ctr, flush, md_busy,
    output md_start, md_ctr, md_lock, md_restore, stall_id, md_done, md_err, op_count
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multi-cycle mult/div unit: launches ops from EX, stalls
// dependent ID instructions, rolls back ops flushed in their first cycle, flags protocol errors.
module md_issue_ctrl (
  input  logic      clk,
  input  logic      reset,
  md_issue_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PEND = 2'b01,
    RUN  = 2'b10
  } state_e;

  localparam logic [3:0] MUL_REM = 4'd4;
  localparam logic [3:0] DIV_REM = 4'd9;

  state_e      state_q, state_d;
  logic [3:0]  rem_q, rem_d;
  logic        md_done_q, md_done_d;
  logic        md_err_q, md_err_d;
  logic [15:0] op_count_q, op_count_d;

  logic        is_muldiv;
  logic        bad_ctr;
  logic        start_ok;
  logic        restore;
  logic        err_hit;

  always_comb begin
    is_muldiv = bus.ex_md_valid && (bus.ex_md_ctr[2] == 1'b0);
    bad_ctr   = bus.ex_md_valid && (bus.ex_md_ctr[2:1] == 2'b11);
  end

  // PEND is the single cycle in which a flush can still cancel the op.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    md_done_d  = 1'b0;
    op_count_d = op_count_q;
    start_ok   = 1'b0;
    restore    = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_muldiv && !bus.flush) begin
          start_ok = 1'b1;
          state_d  = PEND;
          rem_d    = bus.ex_md_ctr[1] ? DIV_REM : MUL_REM;
        end
      end
      PEND: begin
        if (bus.flush) begin
          restore = 1'b1;
          state_d = IDLE;
          rem_d   = '0;
        end else begin
          state_d    = RUN;
          rem_d      = rem_q - 4'd1;
          op_count_d = op_count_q + 16'd1;
        end
      end
      RUN: begin
        rem_d = rem_q - 4'd1;
        if (rem_q == 4'd1) begin
          state_d   = IDLE;
          md_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_comb begin
    err_hit  = bad_ctr
            || (bus.ex_md_valid && (state_q != IDLE))
            || ((state_q == RUN) && (rem_q > 4'd1) && !bus.md_busy)
            || (md_done_q && bus.md_busy);
    md_err_d = md_err_q || err_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      md_done_q  <= 1'b0;
      md_err_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      md_done_q  <= md_done_d;
      md_err_q   <= md_err_d;
      op_count_q <= op_count_d;
    end
  end

  // Combinational outputs are forced low while reset is held; md_lock mirrors flush always.
  always_comb begin
    bus.md_start   = reset && start_ok;
    bus.md_restore = reset && restore;
    bus.md_lock    = bus.flush;
    bus.md_ctr     = bus.ex_md_ctr;
    bus.stall_id   = reset && (bus.id_md_op || bus.id_mf_op)
                  && ((state_q != IDLE) || start_ok);
    bus.md_done    = md_done_q;
    bus.md_err     = md_err_q;
    bus.op_count   = op_count_q;
  end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_md_issue_ctrl;
  logic clk = 1'b0;
  logic reset;

  md_issue_if bus ();

  md_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an op is described by its issue cycle t0 and its latency len.
  int        cyc     = 0;
  bit        active  = 1'b0;
  int        t0      = 0;
  int        len     = 0;
  int        done_at = -1;
  bit [15:0] m_count = 16'd0;
  bit        m_err   = 1'b0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    int k;
    bit inf;
    bit e_start;
    bit e_restore;
    if (!reset) begin
      chk1("rst_start", bus.md_start, 1'b0);
      chk1("rst_restore", bus.md_restore, 1'b0);
      chk1("rst_stall", bus.stall_id, 1'b0);
      chk1("rst_lock", bus.md_lock, bus.flush);
      chk1("rst_done", bus.md_done, 1'b0);
      chk1("rst_err", bus.md_err, 1'b0);
      chk16("rst_count", bus.op_count, 16'h0000);
      active  = 1'b0;
      done_at = -1;
      m_count = 16'd0;
      m_err   = 1'b0;
    end else begin
      k         = cyc - t0;
      inf       = active && (k >= 1) && (k <= len - 1);
      e_start   = !inf && bus.ex_md_valid && (bus.ex_md_ctr < 3'd4) && !bus.flush;
      e_restore = inf && (k == 1) && bus.flush;
      chk1("md_start", bus.md_start, e_start);
      chk1("md_restore", bus.md_restore, e_restore);
      chk1("md_lock", bus.md_lock, bus.flush);
      chk1("stall_id", bus.stall_id, (bus.id_md_op || bus.id_mf_op) && (inf || e_start));
      chk1("md_done", bus.md_done, done_at == cyc);
      chk1("md_err", bus.md_err, m_err);
      chk16("op_count", bus.op_count, m_count);
      chk16("md_ctr", {13'd0, bus.md_ctr}, {13'd0, bus.ex_md_ctr});
      if (bus.ex_md_valid && (bus.ex_md_ctr >= 3'd6)) m_err = 1'b1;
      if (inf && bus.ex_md_valid) m_err = 1'b1;
      if (inf && (k >= 2) && (k <= len - 2) && !bus.md_busy) m_err = 1'b1;
      if ((done_at == cyc) && bus.md_busy) m_err = 1'b1;
      if (e_restore) active = 1'b0;
      else if (inf && (k == 1)) m_count++;
      if (inf && !e_restore && (k == len - 1)) begin
        done_at = cyc + 1;
        active  = 1'b0;
      end
      if (e_start) begin
        active = 1'b1;
        t0     = cyc;
        len    = (bus.ex_md_ctr < 3'd2) ? 5 : 10;
      end
    end
    cyc++;
  end

  task automatic idle_in();
    bus.id_md_op    = 1'b0;
    bus.id_mf_op    = 1'b0;
    bus.ex_md_valid = 1'b0;
    bus.ex_md_ctr   = 3'b000;
    bus.flush       = 1'b0;
    bus.md_busy     = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_in();
    nxt();
    nxt();
    reset = 1'b1;
  endtask

  task automatic issue(input logic [2:0] ctr);
    bus.ex_md_valid = 1'b1;
    bus.ex_md_ctr   = ctr;
    mid();
    chk1("issue_start", bus.md_start, 1'b1);
    nxt();
    bus.ex_md_valid = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle_in();
    nxt();

    // mult with mfhi waiting in ID
    do_reset();
    mid();
    chk16("s1_count_rst", bus.op_count, 16'h0000);
    chk1("s1_done_rst", bus.md_done, 1'b0);
    nxt();
    bus.ex_md_valid = 1'b1;
    bus.ex_md_ctr   = 3'b000;
    bus.id_mf_op    = 1'b1;
    mid();
    chk1("s1_start", bus.md_start, 1'b1);
    chk1("s1_stall_T", bus.stall_id, 1'b1);
    nxt();
    bus.ex_md_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.md_busy = (k <= 4);
      mid();
      chk1("s1_stall", bus.stall_id, k <= 4);
      chk1("s1_done", bus.md_done, k == 5);
      nxt();
    end
    chk16("s1_count", bus.op_count, 16'h0001);
    idle_in();

    // divu latency
    do_reset();
    issue(3'b011);
    for (int k = 1; k <= 11; k++) begin
      bus.md_busy = (k <= 9);
      mid();
      chk1("s2_done", bus.md_done, k == 10);
      nxt();
    end
    chk1("s2_err", bus.md_err, 1'b0);
    chk16("s2_count", bus.op_count, 16'h0001);

    // mult flushed in its first cycle
    do_reset();
    issue(3'b000);
    bus.flush   = 1'b1;
    bus.md_busy = 1'b1;
    mid();
    chk1("s3_restore", bus.md_restore, 1'b1);
    chk1("s3_lock", bus.md_lock, 1'b1);
    nxt();
    idle_in();
    bus.id_md_op = 1'b1;
    mid();
    chk1("s3_idle_stall", bus.stall_id, 1'b0);
    nxt();
    bus.id_md_op = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      mid();
      chk1("s3_done", bus.md_done, 1'b0);
      nxt();
    end
    chk16("s3_count", bus.op_count, 16'h0000);

    // div with a late flush is committed
    do_reset();
    issue(3'b010);
    for (int k = 1; k <= 11; k++) begin
      bus.md_busy = (k <= 9);
      bus.flush   = (k == 3);
      mid();
      chk1("s4_restore", bus.md_restore, 1'b0);
      chk1("s4_done", bus.md_done, k == 10);
      nxt();
    end
    chk16("s4_count", bus.op_count, 16'h0001);
    chk1("s4_err", bus.md_err, 1'b0);

    // flush kills a launch in IDLE
    do_reset();
    bus.ex_md_valid = 1'b1;
    bus.flush       = 1'b1;
    mid();
    chk1("s5_lock", bus.md_lock, 1'b1);
    chk1("s5_start", bus.md_start, 1'b0);
    nxt();
    idle_in();
    bus.id_md_op = 1'b1;
    mid();
    chk1("s5_stall", bus.stall_id, 1'b0);
    nxt();

    // mthi/mtlo pass straight through
    for (int c = 4; c <= 5; c++) begin
      bus.ex_md_valid = 1'b1;
      bus.ex_md_ctr   = 3'(c);
      bus.id_md_op    = 1'b1;
      mid();
      chk1("s6_start", bus.md_start, 1'b0);
      chk1("s6_stall", bus.stall_id, 1'b0);
      nxt();
    end
    idle_in();
    bus.id_md_op = 1'b1;
    mid();
    chk1("s6_stall_after", bus.stall_id, 1'b0);
    nxt();
    idle_in();

    // op_count wraps from 0xFFFF
    do_reset();
    force dut.op_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    #1;
    release dut.op_count_q;
    mid();
    chk16("s7_preload", bus.op_count, 16'hFFFF);
    nxt();
    issue(3'b001);
    bus.md_busy = 1'b1;
    nxt();
    mid();
    chk16("s7_wrap", bus.op_count, 16'h0000);
    nxt();
    for (int k = 3; k <= 5; k++) begin
      bus.md_busy = (k <= 4);
      nxt();
    end
    idle_in();

    // reset two cycles into a div
    do_reset();
    issue(3'b010);
    bus.md_busy = 1'b1;
    nxt();
    reset        = 1'b0;
    bus.id_md_op = 1'b1;
    mid();
    chk1("s8_stall_rst", bus.stall_id, 1'b0);
    chk1("s8_done_rst", bus.md_done, 1'b0);
    chk16("s8_count_rst", bus.op_count, 16'h0000);
    nxt();
    reset       = 1'b1;
    bus.md_busy = 1'b0;
    mid();
    chk1("s8_stall_idle", bus.stall_id, 1'b0);
    nxt();
    bus.id_md_op = 1'b0;
    for (int k = 0; k < 12; k++) begin
      mid();
      chk1("s8_no_done", bus.md_done, 1'b0);
      nxt();
    end
    issue(3'b000);
    for (int k = 1; k <= 5; k++) begin
      bus.md_busy = (k <= 4);
      mid();
      chk1("s8_resume_done", bus.md_done, k == 5);
      nxt();
    end
    idle_in();

    // error: illegal op code, sticky until reset
    do_reset();
    bus.ex_md_valid = 1'b1;
    bus.ex_md_ctr   = 3'b110;
    mid();
    chk1("e1_err_early", bus.md_err, 1'b0);
    nxt();
    idle_in();
    mid();
    chk1("e1_err", bus.md_err, 1'b1);
    nxt();
    nxt();
    nxt();
    mid();
    chk1("e1_sticky", bus.md_err, 1'b1);
    nxt();
    do_reset();
    mid();
    chk1("e1_cleared", bus.md_err, 1'b0);
    nxt();
    bus.ex_md_valid = 1'b1;
    bus.ex_md_ctr   = 3'b111;
    nxt();
    idle_in();
    mid();
    chk1("e5_err", bus.md_err, 1'b1);
    nxt();

    // error: new EX op while one is pending
    do_reset();
    issue(3'b000);
    bus.ex_md_valid = 1'b1;
    bus.md_busy     = 1'b1;
    nxt();
    bus.ex_md_valid = 1'b0;
    mid();
    chk1("e2_err", bus.md_err, 1'b1);
    nxt();

    // error: unit drops busy early
    do_reset();
    issue(3'b010);
    bus.md_busy = 1'b1;
    nxt();
    bus.md_busy = 1'b0;
    nxt();
    mid();
    chk1("e3_err", bus.md_err, 1'b1);
    nxt();

    // busy may drop on the last RUN cycle, but not stay high into done
    do_reset();
    issue(3'b000);
    for (int k = 1; k <= 5; k++) begin
      bus.md_busy = (k <= 3) || (k == 5);
      mid();
      chk1("e4_err_clean", bus.md_err, 1'b0);
      chk1("e4_done", bus.md_done, k == 5);
      nxt();
    end
    bus.md_busy = 1'b0;
    mid();
    chk1("e4_err", bus.md_err, 1'b1);
    nxt();

    // randomized legal traffic with occasional resets
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int  k;
      bit  inf;
      k   = cyc - t0;
      inf = active && (k >= 1) && (k <= len - 1);
      bus.id_md_op = ($urandom_range(0, 2) == 0);
      bus.id_mf_op = ($urandom_range(0, 2) == 0);
      bus.flush    = ($urandom_range(0, 7) == 0);
      if (inf) begin
        bus.ex_md_valid = 1'b0;
        bus.ex_md_ctr   = 3'($urandom_range(0, 7));
        bus.md_busy     = 1'b1;
      end else begin
        bus.ex_md_valid = 1'($urandom_range(0, 1));
        bus.ex_md_ctr   = bus.ex_md_valid ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
        bus.md_busy     = 1'b0;
      end
      reset = ($urandom_range(0, 299) != 0);
      nxt();
    end
    reset = 1'b1;
    idle_in();
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
